y_update_engine: RTL and testbench

- Write-path stage feeding the Y SRAM bus arbiter on its write-path port group.
- Accepts a stream of Y updates (11-bit row index, 256-bit delta) over valid/ready.
- For each update, performs a read-modify-write on the Y SRAM: reads the row, adds the delta lane-wise, writes the row back.
- Raises a done pulse after the update flagged last; is active only while the arbiter grants the write path.

---
 rtl/y_pkg.sv | 25 ++
 rtl/y_lane_adder.sv | 37 +++
 rtl/y_update_engine.sv | 162 ++++++++++++++++
 tb/tb_y_update_engine.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y_pkg.sv
// Shared constants and the FSM state type for the Y update write path.
//   Y_ADDR_W    : Y SRAM row address width (2048 rows)
//   Y_DATA_W    : row width, Y_LANES x Y_LANE_W
//   Y_IDLE_ADDR : address parked on every address output when not accessing
//   Y_LANE_MAX/Y_LANE_MIN : signed lane limits used by the saturating add
package y_pkg;

    localparam int Y_ADDR_W = 11;
    localparam int Y_LANES  = 16;
    localparam int Y_LANE_W = 16;
    localparam int Y_DATA_W = Y_LANES * Y_LANE_W;

    localparam logic [Y_ADDR_W-1:0] Y_IDLE_ADDR = 11'h7ff;

    localparam logic [Y_LANE_W-1:0] Y_LANE_MAX = {1'b0, {(Y_LANE_W-1){1'b1}}};
    localparam logic [Y_LANE_W-1:0] Y_LANE_MIN = {1'b1, {(Y_LANE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } y_upd_state_t;

endpackage

// File: rtl/y_lane_adder.sv
// Combinational lane-wise adder: sum lane i = rowData lane i + delta lane i.
// Lanes are two's complement Y_LANE_W bits.
// Build option: define Y_UPDATE_SAT_EN to saturate each lane to the signed
// range instead of wrapping modulo 2^Y_LANE_W.
//   rowData : current Y row (Y_DATA_W)
//   delta   : update delta (Y_DATA_W)
//   sum     : lane-wise result (Y_DATA_W)
module y_lane_adder
    import y_pkg::*;
(
    input  logic [Y_DATA_W-1:0] rowData,
    input  logic [Y_DATA_W-1:0] delta,
    output logic [Y_DATA_W-1:0] sum
);

    for (genvar i = 0; i < Y_LANES; i++) begin : gLane
        logic [Y_LANE_W-1:0] a;
        logic [Y_LANE_W-1:0] b;

        assign a = rowData[i*Y_LANE_W +: Y_LANE_W];
        assign b = delta[i*Y_LANE_W +: Y_LANE_W];

`ifdef Y_UPDATE_SAT_EN
        // Sign-extended sum; the two top bits differ exactly on overflow and
        // the extra top bit gives the true sign of the result.
        logic [Y_LANE_W:0] ext;
        assign ext = {a[Y_LANE_W-1], a} + {b[Y_LANE_W-1], b};
        assign sum[i*Y_LANE_W +: Y_LANE_W] =
            (ext[Y_LANE_W] != ext[Y_LANE_W-1]) ?
                (ext[Y_LANE_W] ? Y_LANE_MIN : Y_LANE_MAX) :
                ext[Y_LANE_W-1:0];
`else
        assign sum[i*Y_LANE_W +: Y_LANE_W] = a + b;
`endif
    end

endmodule

// File: rtl/y_update_engine.sv
// Y update engine: read-modify-write of one Y SRAM row per accepted update
// (row += delta, lane-wise), driving the arbiter's write-path port group.
// Build option Y_UPDATE_SAT_EN (saturating lanes) lives in y_lane_adder.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   in_enable           : write-path grant from the arbiter
//   in_updValid/op_updReady, in_updAddr, in_updData, in_updLast : update stream
//   in_readData1        : SRAM read port 1 data, one cycle after address
//   op_readAddr1/2      : read addresses (port 2 parked at Y_IDLE_ADDR)
//   op_we, op_writeAddr, op_writeData : SRAM write port
//   op_busy             : not IDLE
//   op_done             : pulse after the write of a last-flagged update
//   op_abort            : pulse when an in-flight update is dropped on grant loss
// All outputs are registered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an update; ready follows the grant
// ISSUE   | read address on op_readAddr1, SRAM samples it this cycle
// CAPTURE | read data valid, lane sum registered into op_writeData
// WRITE   | op_we high for one cycle with the summed row
module y_update_engine
    import y_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_enable,
    input  logic                in_updValid,
    output logic                op_updReady,
    input  logic [Y_ADDR_W-1:0] in_updAddr,
    input  logic [Y_DATA_W-1:0] in_updData,
    input  logic                in_updLast,
    input  logic [Y_DATA_W-1:0] in_readData1,
    output logic [Y_ADDR_W-1:0] op_readAddr1,
    output logic [Y_ADDR_W-1:0] op_readAddr2,
    output logic                op_we,
    output logic [Y_ADDR_W-1:0] op_writeAddr,
    output logic [Y_DATA_W-1:0] op_writeData,
    output logic                op_busy,
    output logic                op_done,
    output logic                op_abort
);

    y_upd_state_t        state, stateNext;
    logic [Y_ADDR_W-1:0] addrQ, addrNext;
    logic [Y_DATA_W-1:0] deltaQ, deltaNext;
    logic                lastQ, lastNext;

    logic [Y_ADDR_W-1:0] readAddr1Next;
    logic                weNext;
    logic [Y_ADDR_W-1:0] writeAddrNext;
    logic [Y_DATA_W-1:0] writeDataNext;
    logic                readyNext;
    logic                busyNext;
    logic                doneNext;
    logic                abortNext;

    logic [Y_DATA_W-1:0] laneSum;

    y_lane_adder uAdder (
        .rowData (in_readData1),
        .delta   (deltaQ),
        .sum     (laneSum)
    );

    always_comb begin
        stateNext     = state;
        addrNext      = addrQ;
        deltaNext     = deltaQ;
        lastNext      = lastQ;
        readAddr1Next = op_readAddr1;
        weNext        = 1'b0;
        writeAddrNext = Y_IDLE_ADDR;
        writeDataNext = '0;
        doneNext      = 1'b0;
        abortNext     = 1'b0;

        case (state)
            IDLE: begin
                // Ready is registered, so an offer seen with ready high is
                // accepted even if the grant drops in this same cycle; the
                // grant check in ISSUE then aborts it.
                if (in_updValid && op_updReady) begin
                    addrNext      = in_updAddr;
                    deltaNext     = in_updData;
                    lastNext      = in_updLast;
                    readAddr1Next = in_updAddr;
                    stateNext     = ISSUE;
                end
            end
            ISSUE: begin
                if (!in_enable) begin
                    abortNext     = 1'b1;
                    readAddr1Next = Y_IDLE_ADDR;
                    stateNext     = IDLE;
                end else begin
                    stateNext = CAPTURE;
                end
            end
            CAPTURE: begin
                readAddr1Next = Y_IDLE_ADDR;
                if (!in_enable) begin
                    abortNext = 1'b1;
                    stateNext = IDLE;
                end else begin
                    weNext        = 1'b1;
                    writeAddrNext = addrQ;
                    writeDataNext = laneSum;
                    stateNext     = WRITE;
                end
            end
            WRITE: begin
                stateNext = IDLE;
                if (!in_enable) begin
                    abortNext = 1'b1;
                end else begin
                    doneNext = lastQ;
                end
            end
            default: begin
                readAddr1Next = Y_IDLE_ADDR;
                stateNext     = IDLE;
            end
        endcase

        readyNext = in_enable && (stateNext == IDLE);
        busyNext  = (stateNext != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            addrQ        <= '0;
            deltaQ       <= '0;
            lastQ        <= 1'b0;
            op_readAddr1 <= Y_IDLE_ADDR;
            op_readAddr2 <= Y_IDLE_ADDR;
            op_we        <= 1'b0;
            op_writeAddr <= Y_IDLE_ADDR;
            op_writeData <= '0;
            op_updReady  <= 1'b0;
            op_busy      <= 1'b0;
            op_done      <= 1'b0;
            op_abort     <= 1'b0;
        end else begin
            state        <= stateNext;
            addrQ        <= addrNext;
            deltaQ       <= deltaNext;
            lastQ        <= lastNext;
            op_readAddr1 <= readAddr1Next;
            op_readAddr2 <= Y_IDLE_ADDR;
            op_we        <= weNext;
            op_writeAddr <= writeAddrNext;
            op_writeData <= writeDataNext;
            op_updReady  <= readyNext;
            op_busy      <= busyNext;
            op_done      <= doneNext;
            op_abort     <= abortNext;
        end
    end

endmodule

// File: tb/tb_y_update_engine.sv
// Self-checking bench for y_update_engine with a behavioural Y SRAM.
module tb_y_update_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_enable;
    logic         in_updValid;
    logic         op_updReady;
    logic [10:0]  in_updAddr;
    logic [255:0] in_updData;
    logic         in_updLast;
    logic [255:0] in_readData1;
    logic [10:0]  op_readAddr1;
    logic [10:0]  op_readAddr2;
    logic         op_we;
    logic [10:0]  op_writeAddr;
    logic [255:0] op_writeData;
    logic         op_busy;
    logic         op_done;
    logic         op_abort;

    y_update_engine dut (
        .clk          (clk),
        .reset        (reset),
        .in_enable    (in_enable),
        .in_updValid  (in_updValid),
        .op_updReady  (op_updReady),
        .in_updAddr   (in_updAddr),
        .in_updData   (in_updData),
        .in_updLast   (in_updLast),
        .in_readData1 (in_readData1),
        .op_readAddr1 (op_readAddr1),
        .op_readAddr2 (op_readAddr2),
        .op_we        (op_we),
        .op_writeAddr (op_writeAddr),
        .op_writeData (op_writeData),
        .op_busy      (op_busy),
        .op_done      (op_done),
        .op_abort     (op_abort)
    );

    always #5 clk = ~clk;

    // Behavioural Y SRAM: synchronous read with one cycle latency, write
    // only while the grant is held. Preload port used by the bench only.
    logic [255:0] mem [2048];
    logic         preloadEn;
    logic [10:0]  preloadAddr;
    logic [255:0] preloadData;

    always @(posedge clk) begin
        in_readData1 <= mem[op_readAddr1];
        if (preloadEn)
            mem[preloadAddr] <= preloadData;
        else if (op_we && in_enable)
            mem[op_writeAddr] <= op_writeData;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [10:0] a, input logic [255:0] d);
        preloadEn   = 1'b1;
        preloadAddr = a;
        preloadData = d;
        tick();
        preloadEn   = 1'b0;
    endtask

    // Lane-wise signed add from plain integer arithmetic.
    function automatic logic [255:0] refAdd(input logic [255:0] y, input logic [255:0] d);
        logic [255:0] r;
        int s;
        for (int i = 0; i < 16; i++) begin
            s = int'($signed(y[i*16 +: 16])) + int'($signed(d[i*16 +: 16]));
`ifdef Y_UPDATE_SAT_EN
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
`endif
            r[i*16 +: 16] = s[15:0];
        end
        return r;
    endfunction

    // One full update from an idle, ready cycle T; checks cycle-exact timing.
    task automatic doSingle(input string nm, input logic [10:0] a, input logic [255:0] d,
                            input logic last, input logic [255:0] expData);
        chk({nm, " ready@T"}, op_updReady, 1'b1);
        in_updValid = 1'b1;
        in_updAddr  = a;
        in_updData  = d;
        in_updLast  = last;
        tick();                                     // T+1 ISSUE
        in_updValid = 1'b0;
        chk({nm, " readAddr1@T+1"}, op_readAddr1, a);
        chk({nm, " busy@T+1"}, op_busy, 1'b1);
        chk({nm, " ready@T+1"}, op_updReady, 1'b0);
        tick();                                     // T+2 CAPTURE
        chk({nm, " we@T+2"}, op_we, 1'b0);
        tick();                                     // T+3 WRITE
        chk({nm, " we@T+3"}, op_we, 1'b1);
        chk({nm, " writeAddr@T+3"}, op_writeAddr, a);
        chk({nm, " writeData@T+3"}, op_writeData, expData);
        tick();                                     // T+4
        chk({nm, " we@T+4"}, op_we, 1'b0);
        chk({nm, " writeAddr@T+4"}, op_writeAddr, 11'h7ff);
        chk({nm, " done@T+4"}, op_done, last);
        chk({nm, " ready@T+4"}, op_updReady, 1'b1);
    endtask

    typedef struct {
        logic [10:0] addr;
        logic [15:0] y;
        logic [15:0] d;
        logic [15:0] expWrap;
        logic [15:0] expSat;
    } vec_t;

    typedef struct packed {
        logic [10:0]  a;
        logic [255:0] d;
    } wr_t;

    initial begin
        vec_t         vecs [7];
        wr_t          q [$];
        wr_t          w;
        logic [255:0] refMem [4];
        logic [15:0]  e;
        logic [255:0] d;
        logic [10:0]  a;
        logic         lastV;
        logic         accepted;
        int           doneCnt;
        int           lastCnt;
        int           abortCnt;

        vecs[0] = '{11'h010, 16'h0005, 16'h0001, 16'h0006, 16'h0006};
        vecs[1] = '{11'h011, 16'h7fff, 16'h0001, 16'h8000, 16'h7fff};
        vecs[2] = '{11'h012, 16'h8000, 16'hffff, 16'h7fff, 16'h8000};
        vecs[3] = '{11'h013, 16'hffff, 16'h0001, 16'h0000, 16'h0000};
        vecs[4] = '{11'h014, 16'h4000, 16'h4000, 16'h8000, 16'h7fff};
        vecs[5] = '{11'h015, 16'h8000, 16'h8000, 16'h0000, 16'h8000};
        vecs[6] = '{11'h7ff, 16'h1234, 16'h0100, 16'h1334, 16'h1334};

        reset       = 1'b0;
        in_enable   = 1'b1;
        in_updValid = 1'b0;
        in_updAddr  = '0;
        in_updData  = '0;
        in_updLast  = 1'b0;
        preloadEn   = 1'b0;
        preloadAddr = '0;
        preloadData = '0;

        // Reset state
        tick();
        tick();
        chk("rst readAddr1", op_readAddr1, 11'h7ff);
        chk("rst readAddr2", op_readAddr2, 11'h7ff);
        chk("rst writeAddr", op_writeAddr, 11'h7ff);
        chk("rst we", op_we, 1'b0);
        chk("rst writeData", op_writeData, '0);
        chk("rst ready", op_updReady, 1'b0);
        chk("rst busy", op_busy, 1'b0);
        chk("rst done", op_done, 1'b0);
        chk("rst abort", op_abort, 1'b0);
        reset = 1'b1;
        tick();
        chk("idle ready", op_updReady, 1'b1);
        chk("idle busy", op_busy, 1'b0);
        chk("idle readAddr1", op_readAddr1, 11'h7ff);

        // Table-driven single updates, all lanes carry the same pattern
        for (int i = 0; i < 7; i++) begin
`ifdef Y_UPDATE_SAT_EN
            e = vecs[i].expSat;
`else
            e = vecs[i].expWrap;
`endif
            preload(vecs[i].addr, {16{vecs[i].y}});
            doSingle($sformatf("vec%0d", i), vecs[i].addr, {16{vecs[i].d}}, i[0] == 1'b0, {16{e}});
        end

        // Back-to-back updates to the same row
        preload(11'h020, '0);
        doneCnt     = 0;
        in_updValid = 1'b1;
        in_updAddr  = 11'h020;
        in_updData  = {16{16'h0002}};
        in_updLast  = 1'b0;
        tick();                                     // T+1
        in_updLast = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) chk("b2b first write", op_writeData, {16{16'h0002}});
            if (c == 4) chk("b2b ready reasserts", op_updReady, 1'b1);
            if (c == 6) chk("b2b second read", in_readData1, {16{16'h0002}});
            if (c == 7) chk("b2b second write", op_writeData, {16{16'h0004}});
            if (op_done) doneCnt++;
            tick();
            if (c == 4) in_updValid = 1'b0;
        end
        chk("b2b done count", doneCnt, 1);
        chk("b2b final row", mem[11'h020], {16{16'h0004}});

        // Grant loss during CAPTURE
        preload(11'h030, {16{16'h0100}});
        in_updValid = 1'b1;
        in_updAddr  = 11'h030;
        in_updData  = {16{16'h0001}};
        in_updLast  = 1'b1;
        tick();                                     // ISSUE
        in_updValid = 1'b0;
        tick();                                     // CAPTURE
        in_enable = 1'b0;
        tick();
        chk("abort we", op_we, 1'b0);
        chk("abort pulse", op_abort, 1'b1);
        chk("abort busy", op_busy, 1'b0);
        chk("abort ready", op_updReady, 1'b0);
        in_enable = 1'b1;
        tick();
        chk("abort one cycle", op_abort, 1'b0);
        chk("abort no done", op_done, 1'b0);
        chk("abort no we", op_we, 1'b0);
        chk("abort ready back", op_updReady, 1'b1);
        chk("abort row kept", mem[11'h030], {16{16'h0100}});

        // Reset during WRITE
        in_updValid = 1'b1;
        in_updAddr  = 11'h040;
        in_updData  = {16{16'h0003}};
        in_updLast  = 1'b1;
        tick();                                     // ISSUE
        in_updValid = 1'b0;
        tick();                                     // CAPTURE
        tick();                                     // WRITE
        chk("rstw we in WRITE", op_we, 1'b1);
        reset = 1'b0;
        tick();
        chk("rstw we", op_we, 1'b0);
        chk("rstw writeAddr", op_writeAddr, 11'h7ff);
        chk("rstw busy", op_busy, 1'b0);
        chk("rstw done", op_done, 1'b0);
        chk("rstw abort", op_abort, 1'b0);
        reset = 1'b1;
        tick();
        chk("rstw done after", op_done, 1'b0);
        chk("rstw abort after", op_abort, 1'b0);
        chk("rstw ready", op_updReady, 1'b1);

        // Randomized stream against a transaction-level model
        for (int r = 0; r < 4; r++) begin
            refMem[r] = {8{$urandom}};
            preload(11'h100 + 11'(r), refMem[r]);
        end
        doneCnt  = 0;
        lastCnt  = 0;
        abortCnt = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!in_updValid && c < 1450 && ($urandom_range(0, 2) != 0)) begin
                for (int l = 0; l < 16; l++) begin
                    case ($urandom_range(0, 4))
                        0: d[l*16 +: 16] = 16'h7fff;
                        1: d[l*16 +: 16] = 16'h8000;
                        2: d[l*16 +: 16] = 16'hffff;
                        3: d[l*16 +: 16] = 16'h0001;
                        default: d[l*16 +: 16] = 16'($urandom);
                    endcase
                end
                in_updValid = 1'b1;
                in_updAddr  = 11'h100 + 11'($urandom_range(0, 3));
                in_updData  = d;
                in_updLast  = ($urandom_range(0, 3) == 0);
            end
            accepted = in_updValid && op_updReady;
            a        = in_updAddr;
            d        = in_updData;
            lastV    = in_updLast;
            tick();
            if (accepted) begin
                refMem[a[1:0]] = refAdd(refMem[a[1:0]], d);
                q.push_back('{a, refMem[a[1:0]]});
                if (lastV) lastCnt++;
                in_updValid = 1'b0;
            end
            if (op_we) begin
                if (q.size() == 0) begin
                    chk("rand unexpected we", op_we, 1'b0);
                end else begin
                    w = q.pop_front();
                    chk("rand writeAddr", op_writeAddr, w.a);
                    chk("rand writeData", op_writeData, w.d);
                end
            end
            if (op_done) doneCnt++;
            if (op_abort) abortCnt++;
        end
        chk("rand queue drained", q.size(), 0);
        chk("rand done count", doneCnt, lastCnt);
        chk("rand no abort", abortCnt, 0);
        for (int r = 0; r < 4; r++)
            chk($sformatf("rand row %0d", r), mem[11'h100 + 11'(r)], refMem[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
